// File: rtl/quad_mac_pkg.sv
// rtl/quad_mac_pkg.sv - shared types and constants for the quadratic MAC scheduler
package quad_mac_pkg;

    localparam int DW_DEF = 16;

    function automatic int aw_of(input int dw);
        return 3 * dw + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP1 = 2'd1,
        STEP2 = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] CFG_A = 2'd0;
    localparam logic [1:0] CFG_B = 2'd1;
    localparam logic [1:0] CFG_C = 2'd2;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-request round-robin grant with a registered priority pointer
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    always_comb begin
        o_gnt = 2'b00;
        if (!r_ptr) begin
            if (i_req[0])      o_gnt = 2'b01;
            else if (i_req[1]) o_gnt = 2'b10;
        end else begin
            if (i_req[1])      o_gnt = 2'b10;
            else if (i_req[0]) o_gnt = 2'b01;
        end
    end

    // Advancing moves priority to the requester that was not just granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= o_gnt[0];
        end
    end

endmodule

// File: rtl/quad_mac_sched.sv
// rtl/quad_mac_sched.sv - shares one Horner MAC (a*x+b, then acc*x+c) between two job-locked requesters
module quad_mac_sched
    import quad_mac_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           in_valid,
    output logic [1:0]           in_ready,
    input  logic [DW-1:0]        in_x0,
    input  logic [DW-1:0]        in_x1,
    input  logic [1:0]           in_last,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_sel,
    input  logic [DW-1:0]        cfg_data,
    output logic                 cfg_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*DW+1:0]      out_y,
    output logic                 out_id,
    output logic                 out_last,
    output logic                 busy
);

    localparam int AW = aw_of(DW);

    state_t                r_state, w_next;
    logic                  r_lock, r_owner, r_id, r_last;
    logic signed [DW-1:0]  r_a, r_b, r_c, r_x;
    logic signed [AW-1:0]  r_acc, r_y;
    logic                  r_out_valid, r_out_id, r_out_last, r_cfg_err;

    logic [1:0]            w_arb_req, w_gnt;
    logic                  w_hs, w_out_hs, w_advance, w_busy, w_sel_id;
    logic signed [AW-1:0]  w_a_aw, w_b_aw, w_c_aw, w_x_aw, w_step1, w_step2;

    // While a job is locked the arbiter only ever sees the owner, so it grants the owner.
    assign w_arb_req = r_lock ? (r_owner ? 2'b10 : 2'b01) : in_valid;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_req     (w_arb_req),
        .i_advance (w_advance),
        .o_gnt     (w_gnt)
    );

    assign in_ready  = (r_state == IDLE) ? w_gnt : 2'b00;
    assign w_hs      = |(in_ready & in_valid);
    assign w_sel_id  = w_gnt[1];
    assign w_out_hs  = (r_state == HOLD) && out_ready;
    assign w_advance = w_out_hs && r_out_last;
    assign w_busy    = (r_state != IDLE) || r_lock;

    // AW-wide products keep the exact low AW bits; the true results always fit.
    assign w_a_aw  = {{(AW-DW){r_a[DW-1]}}, r_a};
    assign w_b_aw  = {{(AW-DW){r_b[DW-1]}}, r_b};
    assign w_c_aw  = {{(AW-DW){r_c[DW-1]}}, r_c};
    assign w_x_aw  = {{(AW-DW){r_x[DW-1]}}, r_x};
    assign w_step1 = w_a_aw * w_x_aw + w_b_aw;
    assign w_step2 = r_acc * w_x_aw + w_c_aw;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next = STEP1;
            STEP1:   w_next = STEP2;
            STEP2:   w_next = HOLD;
            HOLD:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_lock      <= 1'b0;
            r_owner     <= 1'b0;
            r_id        <= 1'b0;
            r_last      <= 1'b0;
            r_x         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_acc       <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= 1'b0;
            r_out_last  <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_x     <= w_sel_id ? in_x1 : in_x0;
                r_id    <= w_sel_id;
                r_last  <= in_last[w_sel_id];
                r_lock  <= 1'b1;
                r_owner <= w_sel_id;
            end
            if (r_state == STEP1) begin
                r_acc <= w_step1;
            end
            if (r_state == STEP2) begin
                r_y         <= w_step2;
                r_out_valid <= 1'b1;
                r_out_id    <= r_id;
                r_out_last  <= r_last;
            end
            if (w_out_hs) begin
                r_out_valid <= 1'b0;
                if (r_out_last) r_lock <= 1'b0;
            end
            if (cfg_we && !w_busy) begin
                case (cfg_sel)
                    CFG_A:   r_a <= cfg_data;
                    CFG_B:   r_b <= cfg_data;
                    CFG_C:   r_c <= cfg_data;
                    default: ;
                endcase
            end
            r_cfg_err <= cfg_we && (w_busy || (cfg_sel == 2'd3));
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_y;
    assign out_id    = r_out_id;
    assign out_last  = r_out_last;
    assign cfg_err   = r_cfg_err;
    assign busy      = w_busy;

endmodule

// File: tb/tb_quad_mac_sched.sv
// tb/tb_quad_mac_sched.sv - directed self-checking bench for quad_mac_sched
module tb_quad_mac_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  in_valid = 2'b00;
    logic [1:0]  in_ready;
    logic [15:0] in_x0 = '0;
    logic [15:0] in_x1 = '0;
    logic [1:0]  in_last = 2'b00;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [15:0] cfg_data = '0;
    logic        cfg_err;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [49:0] out_y;
    logic        out_id;
    logic        out_last;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic signed [15:0] a, b, c, x;
        longint             y;
    } vec_t;

    vec_t vecs[6];

    quad_mac_sched dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x0     (in_x0),
        .in_x1     (in_x1),
        .in_last   (in_last),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_id    (out_id),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg_wr(input logic [1:0] sel, input logic [15:0] d, input logic exp_err, input string name);
        cfg_we = 1'b1; cfg_sel = sel; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        chk({name, "_err"}, longint'(cfg_err), longint'(exp_err));
        @(negedge clk);
        chk({name, "_err_clear"}, longint'(cfg_err), 0);
    endtask

    task automatic send(input int id, input logic signed [15:0] x, input logic last);
        int n = 0;
        if (id == 0) in_x0 = x; else in_x1 = x;
        in_last[id]  = last;
        in_valid[id] = 1'b1;
        #1;
        while (!in_ready[id] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("grant_timeout", longint'(n < 50), 1);
        @(negedge clk);
        in_valid[id] = 1'b0;
    endtask

    task automatic expect_result(input string name, input longint y, input logic id, input logic last);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk); n++;
        end
        chk({name, "_latency"}, n, 2);
        chk({name, "_y"}, longint'($signed(out_y)), y);
        chk({name, "_id"}, longint'(out_id), longint'(id));
        chk({name, "_last"}, longint'(out_last), longint'(last));
    endtask

    task automatic do_sample(input int id, input logic signed [15:0] x, input logic last,
                             input longint y, input string name);
        send(id, x, last);
        expect_result(name, y, id[0], last);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'sd1,      16'sd2,     16'sd3,     16'sd2,      64'sd11};
        vecs[1] = '{16'sd1,      16'sd2,     16'sd3,     -16'sd3,     64'sd6};
        vecs[2] = '{16'sh8000,   16'sd0,     16'sd0,     16'sh8000,   -64'sd35184372088832};
        vecs[3] = '{16'sd5,      -16'sd7,    16'sd100,   16'sd10,     64'sd530};
        vecs[4] = '{-16'sd2,     16'sd3,     -16'sd1,    -16'sd4,     -64'sd45};
        vecs[5] = '{16'sd32767,  16'sd32767, 16'sd32767, 16'sd32767,  64'sd35182224670719};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_y", longint'(out_y), 0);
        chk("rst_cfg_err", longint'(cfg_err), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            cfg_wr(2'd0, vecs[i].a, 1'b0, "vec_cfg_a");
            cfg_wr(2'd1, vecs[i].b, 1'b0, "vec_cfg_b");
            cfg_wr(2'd2, vecs[i].c, 1'b0, "vec_cfg_c");
            do_sample(0, vecs[i].x, 1'b1, vecs[i].y, $sformatf("vec%0d", i));
        end

        // Both requesters valid from reset: requester 0's whole job first.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cfg_wr(2'd1, 16'sd1, 1'b0, "rr_cfg_b");
        in_x1 = 16'sd20; in_last[1] = 1'b0; in_valid[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            do_sample(0, 16'(10 + k), (k == 2), 10 + k, $sformatf("rr0_%0d", k));
            if (k < 2) begin
                for (int g = 0; g < 3; g++) begin
                    #1;
                    chk("rr_gap_ready1", longint'(in_ready[1]), 0);
                    chk("rr_gap_busy", longint'(busy), 1);
                    @(negedge clk);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            do_sample(1, 16'(20 + k), (k == 2), 20 + k, $sformatf("rr1_%0d", k));
        end
        in_valid = 2'b00;

        // Back-pressure: coefficients all 0 except b=1 -> y = x.
        out_ready = 1'b0;
        send(0, 16'sd7, 1'b1);
        expect_result("bp", 7, 1'b0, 1'b1);
        in_valid = 2'b11;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("bp_valid", longint'(out_valid), 1);
            chk("bp_y", longint'($signed(out_y)), 7);
            chk("bp_id_last", longint'({out_id, out_last}), 1);
            chk("bp_in_ready", longint'(in_ready), 0);
        end
        in_valid = 2'b00;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", longint'(out_valid), 0);
        chk("bp_release_busy", longint'(busy), 0);

        // Coefficient writes against busy.
        cfg_wr(2'd0, 16'sd1, 1'b0, "cf_a");
        cfg_wr(2'd1, 16'sd2, 1'b0, "cf_b");
        cfg_wr(2'd2, 16'sd3, 1'b0, "cf_c");
        do_sample(0, 16'sd2, 1'b0, 11, "cf_mid");
        chk("cf_locked_busy", longint'(busy), 1);
        cfg_wr(2'd0, 16'sd7, 1'b1, "cf_busy_drop");
        do_sample(0, 16'sd2, 1'b1, 11, "cf_a_unchanged");
        cfg_wr(2'd0, 16'sd7, 1'b0, "cf_accept");
        do_sample(0, 16'sd2, 1'b1, 35, "cf_a_new");
        cfg_wr(2'd3, 16'sd5, 1'b1, "cf_reserved");
        do_sample(0, 16'sd2, 1'b1, 35, "cf_after_reserved");

        // Reset in STEP2 while the pointer favours requester 1.
        send(0, 16'sd4, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_y", longint'(out_y), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 0);
        chk("mid_rst_id_last_err", longint'({out_id, out_last, cfg_err}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        in_x1 = 16'sd9; in_last[1] = 1'b1; in_valid[1] = 1'b1;
        in_valid[0] = 1'b1;
        #1;
        chk("post_rst_grant", longint'(in_ready), 1);
        in_valid[0] = 1'b0;
        do_sample(0, 16'sd5, 1'b1, 0, "post_rst_r0");
        do_sample(1, 16'sd9, 1'b1, 0, "post_rst_r1");
        in_valid = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_mac_sched.md
# quad_mac_sched

Scheduler that shares one quadratic-evaluation MAC between two requesters. Each requester streams samples x and gets y = a·x² + b·x + c, computed by Horner's method in two MAC steps (a·x + b, then acc·x + c). Arbitration is round-robin at job granularity: a job is a burst of samples ending with `last`. Coefficients are a shared register set loaded through a config port. The block sits between the input stream sources and the result sink, and replaces the per-mode enable FSM as the owner of the MAC.

## Interface
Parameters:
- DW, 16: width of x and of coefficients a, b and c (signed two's complement).
- AW, 3*DW+2 (localparam, not overridable): accumulator and result width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  2  per-requester sample valid.
- in_ready  out  2  per-requester sample ready (combinational).
- in_x0, in_x1  in  DW  sample of requester 0 / 1.
- in_last  in  2  per-requester marker: this sample ends the job.
- cfg_we  in  1  coefficient write strobe.
- cfg_sel  in  2  coefficient select: 0=a, 1=b, 2=c, 3=reserved (write dropped).
- cfg_data  in  DW  coefficient value.
- cfg_err  out  1  one-cycle pulse when a write is dropped.
- out_valid  out  1  result valid.
- out_ready  in  1  sink ready.
- out_y  out  AW  result.
- out_id  out  1  requester that owns out_y.
- out_last  out  1  out_y is the last result of its job.
- busy  out  1  high when state ≠ IDLE or a job lock is held.

## Operation
- States: IDLE, STEP1, STEP2, HOLD.
- IDLE:
  - in_ready[i] = 1 only for the granted requester.
  - When a job lock is held, the granted requester is `owner`.
  - Otherwise it is the round-robin winner among in_valid: priority goes to the requester not served last; the pointer resets to favour requester 0.
  - On handshake: capture x, id and last; set lock and owner = id; go to STEP1.
- STEP1: acc ← a·x + b, sign-extended to AW; go to STEP2.
- STEP2: out_y ← acc·x + c; out_valid ← 1; out_id and out_last ← captured values; go to HOLD.
- HOLD: out_valid stays high and out_y/out_id/out_last stay stable until out_ready. On that handshake:
  - out_valid ← 0; go to IDLE.
  - If out_last was 1: release the lock and move the rr pointer past owner.
- Arithmetic:
  - Full-precision signed arithmetic; AW bits guarantee no overflow.
  - The product acc·x is truncated to AW. This is exact because |a·x²+b·x| fits in AW.
- Config writes:
  - Accepted only when busy = 0.
  - Otherwise, or when cfg_sel = 3, the write is dropped and cfg_err pulses the next cycle.
  - A write accepted in the same cycle as a sample handshake in IDLE: busy is still 0, so the write takes effect and the new coefficient is used by that sample. STEP1 reads registers one cycle later.
- While locked:
  - The other requester's in_ready stays 0 even if the owner has in_valid = 0.
  - The owner may idle indefinitely mid-job.
- Only the granted requester's in_last is sampled. in_valid of the non-granted requester is ignored.

## Timing
- Reset (reset_n low, asynchronous):
  - state = IDLE; lock = 0; owner = 0; rr pointer favours requester 0.
  - a = b = c = 0; acc = 0.
  - Outputs: out_valid = 0, out_y = 0, out_id = 0, out_last = 0, cfg_err = 0, busy = 0, in_ready = 0.
  - Reset mid-job discards the job and any pending result.
- Latency: a sample accepted at edge t gives out_valid = 1 after edge t+2.
- Minimum sample period is 4 cycles (IDLE, STEP1, STEP2, HOLD with out_ready = 1).
- Back-pressure: each extra cycle with out_ready = 0 adds one cycle; no sample is accepted while in HOLD.
- Simultaneous in_valid on both requesters with no lock: the winner follows the rr pointer. The loser waits for the end of the winner's whole job.

## Structure
- Package quad_mac_pkg holds:
  - the state enum (IDLE, STEP1, STEP2, HOLD);
  - cfg_sel codes CFG_A, CFG_B, CFG_C;
  - the DW default and the AW formula.
- Sub-module rr_arbiter2:
  - contents: two-request round-robin grant with a registered pointer;
  - inputs: req[1:0], advance (pointer update pulse);
  - outputs: gnt[1:0].
  - Lock handling stays in the top level.

## Test plan
- a=1, b=2, c=3 loaded; requester 0 sends x=2 with last=1 → out_y=11, out_id=0, out_last=1, out_valid at 2 cycles after the handshake.
- Same coefficients, x=−3 → out_y=6. Then a=−32768, b=0, c=0, x=−32768 → out_y=−2^45 exactly (width check).
- Both requesters assert in_valid from reset, each job 3 samples → requester 0's 3 results first, then requester 1's 3. Requester 1's in_ready stays 0 throughout requester 0's job, even during idle gaps in requester 0's stream.
- out_ready held 0 for 5 cycles in HOLD → out_y/out_id/out_last stable and in_ready = 0 throughout; release gives one result, then IDLE.
- cfg_we with cfg_sel=0 while busy → cfg_err pulses once and a is unchanged. Same write with busy = 0 is accepted; cfg_sel=3 pulses cfg_err.
- reset_n pulsed low during STEP2 → all outputs 0 immediately, coefficients 0, the next job is granted to requester 0.
